// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
//   Shares one 16-bit SPI engine between two requesters. Arbitration is
//   round-robin on ties. Every transaction ends with a single ack pulse to its
//   owner, even when the engine never answers (timeout abort, err=1).
//
// Ports
//   clk                 system clock, rising edge
//   reset_n             asynchronous active-low reset
//   req0/req1           requests, held until the matching ack
//   wdata0/wdata1       frame to send for each requester
//   ack0/ack1           one-cycle completion pulse per requester
//   rdata0/rdata1       received frame per requester (0 after an abort)
//   err                 high together with ack when the transaction timed out
//   spi_start           one-cycle start pulse to the SPI engine
//   spi_data_in_16bit   frame presented to the SPI engine
//   spi_busy            SPI engine busy flag
//   spi_data_out_16bit  frame returned by the engine, valid as busy falls
//   grant               one-hot current owner (00 = none)
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// ST_IDLE        | no owner; arbitrate on any request
// ST_WAIT_ACCEPT | start issued, waiting for the engine to raise busy
// ST_WAIT_DONE   | engine busy, waiting for busy to fall
// ST_RELEASE     | one dead cycle; ack/err visible, round-robin pointer moves

module spi_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        err,
  output logic        spi_start,
  output logic [15:0] spi_data_in_16bit,
  input  logic        spi_busy,
  input  logic [15:0] spi_data_out_16bit,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_ACCEPT,
    ST_WAIT_DONE,
    ST_RELEASE
  } state_t;

  // Down-counter: loaded with TIMEOUT_CYCLES-1 on entry to each wait state,
  // so the terminal count is hit in the TIMEOUT_CYCLES-th cycle of that state.
  localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] tmr;
  logic        owner;       // 0 = requester 0, 1 = requester 1
  logic        last_grant;  // owner of the most recently finished transaction
  logic        tmr_tc;
  logic        finish_ok;
  logic        finish_abort;
  logic        pick;

  assign tmr_tc       = (tmr == '0);
  assign finish_ok    = (state == ST_WAIT_DONE) && !spi_busy;
  // An engine edge in the terminal cycle still counts as progress.
  assign finish_abort = tmr_tc && (((state == ST_WAIT_ACCEPT) && !spi_busy) ||
                                   ((state == ST_WAIT_DONE)   &&  spi_busy));
  // Tie goes to whoever did not finish last; otherwise the lone requester.
  assign pick         = (req0 && req1) ? ~last_grant : req1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      tmr               <= '0;
      owner             <= 1'b0;
      last_grant        <= 1'b1;
      grant             <= 2'b00;
      spi_start         <= 1'b0;
      spi_data_in_16bit <= '0;
      ack0              <= 1'b0;
      ack1              <= 1'b0;
      err               <= 1'b0;
      rdata0            <= '0;
      rdata1            <= '0;
    end else begin
      spi_start <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            owner             <= pick;
            grant             <= pick ? 2'b10 : 2'b01;
            spi_data_in_16bit <= pick ? wdata1 : wdata0;
            spi_start         <= 1'b1;
            tmr               <= TMR_LOAD;
            state             <= ST_WAIT_ACCEPT;
          end
        end
        ST_WAIT_ACCEPT, ST_WAIT_DONE: begin
          if (finish_ok || finish_abort) begin
            state <= ST_RELEASE;
            grant <= 2'b00;
            err   <= finish_abort;
            tmr   <= '0;
            if (owner) begin
              ack1   <= 1'b1;
              rdata1 <= finish_abort ? 16'h0000 : spi_data_out_16bit;
            end else begin
              ack0   <= 1'b1;
              rdata0 <= finish_abort ? 16'h0000 : spi_data_out_16bit;
            end
          end else if ((state == ST_WAIT_ACCEPT) && spi_busy) begin
            state <= ST_WAIT_DONE;
            tmr   <= TMR_LOAD;
          end else begin
            tmr <= tmr - 16'd1;
          end
        end
        ST_RELEASE: begin
          last_grant <= owner;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096, max clk cycles spent in WAIT_ACCEPT or in WAIT_DONE before abort; legal range 2..65535.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 req0, req1  input  1 each  transaction request from requester 0 / 1, held high until matching ack.
REQ-005 wdata0, wdata1  input  16 each  16-bit SPI frame to send for requester 0 / 1, stable while req high.
REQ-006 ack0, ack1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-007 rdata0, rdata1  output  16 each  frame received for requester 0 / 1, valid from ack pulse until next ack to that requester.
REQ-008 err  output  1  high with the ack pulse when the transaction aborted on timeout, else low.
REQ-009 spi_start  output  1  one-cycle start pulse to the 16-bit SPI engine.
REQ-010 spi_data_in_16bit  output  16  frame driven to the SPI engine.
REQ-011 spi_busy  input  1  SPI engine busy flag.
REQ-012 spi_data_out_16bit  input  16  frame returned by the SPI engine, valid when spi_busy falls.
REQ-013 grant  output  2  one-hot owner (01 = requester 0, 10 = requester 1, 00 = none).

Function
REQ-014 States: IDLE, WAIT_ACCEPT, WAIT_DONE, RELEASE; all outputs registered.
REQ-015 IDLE, no req: stay IDLE, grant=00.
REQ-016 IDLE, exactly one req high: on that edge grant that requester, latch its wdata into spi_data_in_16bit, set spi_start=1, go WAIT_ACCEPT.
REQ-017 IDLE, both req high: grant the requester not granted last (round-robin via last_grant register), same actions as REQ-016.
REQ-018 spi_start SHALL be high for exactly one cycle per transaction (the first WAIT_ACCEPT cycle).
REQ-019 WAIT_ACCEPT: spi_busy=1 -> WAIT_DONE with timeout counter cleared; else count.
REQ-020 WAIT_DONE: spi_busy=0 -> copy spi_data_out_16bit to rdata of owner, pulse owner ack for one cycle, err=0, go RELEASE; else count.
REQ-021 Timeout: counter reaching TIMEOUT_CYCLES in WAIT_ACCEPT or WAIT_DONE -> owner rdata=16'h0000, owner ack and err pulsed one cycle, go RELEASE.
REQ-022 RELEASE: one cycle, grant=00, last_grant updated to the finished owner, then IDLE; no arbitration in RELEASE.
REQ-023 Requester SHALL drop req in the cycle after ack; req still high in IDLE counts as a new request.
REQ-024 Owner dropping req mid-transaction: transaction completes, ack still issued.
REQ-025 spi_data_in_16bit SHALL hold the latched frame unchanged from grant until the next grant; wdata changes after grant are ignored.
REQ-026 Non-owner rdata and ack SHALL not change during another requester's transaction.
REQ-027 Latency, zero-latency SPI engine excluded: req sampled in IDLE at edge N -> spi_start high in cycle N+1; ack one cycle after spi_busy is sampled low in WAIT_DONE.

Reset
REQ-028 reset_n low SHALL force, asynchronously: state IDLE, grant=00, spi_start=0, spi_data_in_16bit=0, ack0=ack1=0, err=0, rdata0=rdata1=16'h0000, timeout counter 0, last_grant=requester 1 (so requester 0 wins first tie).
REQ-029 Reset mid-transaction SHALL abort without ack; after release the block starts in IDLE and re-arbitrates held requests.

Verification
REQ-030 req0 only, wdata0=16'hB200, engine busy 3..20 cycles returning 16'h00E5 -> spi_start one pulse, ack0 once, rdata0=16'h00E5, err=0, grant 01 then 00.
REQ-031 req0 and req1 same cycle after reset -> requester 0 served first, then requester 1; repeat with both held -> order alternates 0,1,0,1.
REQ-032 spi_busy never rises, TIMEOUT_CYCLES=8 -> ack1 with err=1 and rdata1=16'h0000 after 8 WAIT_ACCEPT cycles, then IDLE.
REQ-033 wdata1 changed to 16'hFFFF one cycle after grant -> spi_data_in_16bit keeps originally latched value to completion.
REQ-034 reset_n pulsed low during WAIT_DONE -> all outputs at reset values immediately, no ack; held req0 served normally after release.
REQ-035 req0 dropped during WAIT_DONE -> ack0 still pulses once, rdata0 updated, no second transaction.
